// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the run sequencer and its DMem port mux.
// The state encoding is 2 bits; the host owns the DMem port in IDLE and DONE.
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DONE_PC_DEFAULT    = 200;
  localparam int MAX_CYCLES_DEFAULT = 4096;
  localparam int CNT_W              = 16;

  function automatic logic is_host_side(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// Single DMem port arbitration between the core and the host port, plus the
// registered host read-data path.
module dmem_port_mux
  import run_seq_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    state,
  input  logic          core_en,
  input  logic          start,
  input  logic          abort,
  input  logic          core_wen,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdat,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdat,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdat,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat
);

  logic host_side;
  logic gnt;
  logic rd_gnt;

  // A start or abort in the same cycle takes priority; the host simply retries.
  always_comb begin
    host_side = is_host_side(state_t'(state));
    gnt       = host_side & host_req & ~start & ~abort;
    rd_gnt    = gnt & ~host_we;
    if (host_side) begin
      mem_wen  = gnt & host_we;
      mem_addr = host_addr;
      mem_wdat = host_wdat;
    end else begin
      mem_wen  = core_wen & core_en;
      mem_addr = core_addr;
      mem_wdat = core_wdat;
    end
  end

  assign host_gnt = gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rvalid <= 1'b0;
      host_rdat   <= '0;
    end else begin
      host_rvalid <= rd_gnt & ~abort;
      if (rd_gnt) begin
        host_rdat <= mem_rdat;
      end
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: owns core reset/enable, sequences
// load -> run -> done with a PC-limit finish and a cycle watchdog.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int PC_W       = 12,
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int DONE_PC    = DONE_PC_DEFAULT,
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc,
  output logic             core_rst_n,
  output logic             core_en,
  input  logic             core_wen,
  input  logic [AW-1:0]    core_addr,
  input  logic [DW-1:0]    core_wdat,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdat,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [DW-1:0]    host_rdat,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdat,
  input  logic [DW-1:0]    mem_rdat,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [PC_W-1:0]  PC_LIMIT = PC_W'(DONE_PC);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state;
  state_t           state_nx;
  logic             pc_past_end;
  logic             wd_hit;
  logic             core_rst_n_nx;
  logic             core_en_nx;
  logic             busy_nx;
  logic             done_nx;
  logic             timeout_nx;
  logic [CNT_W-1:0] cycle_cnt_nx;

  always_comb begin
    pc_past_end  = (pc > PC_LIMIT);
    wd_hit       = (cycle_cnt == WD_LAST);
    state_nx     = state;
    timeout_nx   = timeout;
    cycle_cnt_nx = cycle_cnt;

    case (state)
      IDLE: if (start) state_nx = ARM;
      ARM:  state_nx = RUN;
      RUN: begin
        cycle_cnt_nx = sat_inc(cycle_cnt);
        // PC completion is judged first so a same-cycle watchdog hit is not a timeout.
        if (pc_past_end) begin
          state_nx = DONE;
        end else if (wd_hit) begin
          state_nx   = DONE;
          timeout_nx = 1'b1;
        end
      end
      DONE: if (start) state_nx = ARM;
      default: state_nx = IDLE;
    endcase

    if (abort) begin
      state_nx   = IDLE;
      timeout_nx = 1'b0;
    end

    // Entering ARM wipes the previous run's statistics so they read clear during ARM.
    if (state_nx == ARM) begin
      cycle_cnt_nx = '0;
      timeout_nx   = 1'b0;
    end

    core_rst_n_nx = (state_nx == RUN) || (state_nx == DONE);
    core_en_nx    = (state_nx == RUN);
    busy_nx       = (state_nx == ARM) || (state_nx == RUN);
    done_nx       = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      core_rst_n <= 1'b0;
      core_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state      <= state_nx;
      core_rst_n <= core_rst_n_nx;
      core_en    <= core_en_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      timeout    <= timeout_nx;
      cycle_cnt  <= cycle_cnt_nx;
    end
  end

  dmem_port_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .core_en    (core_en),
    .start      (start),
    .abort      (abort),
    .core_wen   (core_wen),
    .core_addr  (core_addr),
    .core_wdat  (core_wdat),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdat  (host_wdat),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdat  (host_rdat),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdat   (mem_wdat),
    .mem_rdat   (mem_rdat)
  );

endmodule
